exception_arbiter: RTL and testbench

//  Collects exception/interrupt requests from NSRC sources and latches them as sticky pending bits.

---
 rtl/exception_arbiter.sv | 124 ++++++++++++
 tb/tb_exception_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/exception_arbiter.sv
// rtl/exception_arbiter.sv - sticky exception request arbiter with fixed priority
// Latches source requests, raises one to the datapath and blocks nesting until ERet.
module exception_arbiter #(
    parameter int              NSRC     = 4,
    parameter logic [NSRC-1:0] MASK_RST = '1,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NSRC-1:0]  src_req,
    input  logic             cfg_we,
    input  logic [NSRC-1:0]  cfg_mask,
    input  logic             ExcAck,
    input  logic             ERet,
    output logic             Exc,
    output logic [3:0]       EStatus,
    output logic [NSRC-1:0]  src_ack,
    output logic             in_handler,
    output logic             bad_eret,
    output logic [CNT_W-1:0] exc_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RAISE,
        ST_SERVICE
    } state_t;

    state_t           state_q, state_d;
    logic [NSRC-1:0]  pending_q, pending_d;
    logic [NSRC-1:0]  mask_q, mask_d;
    logic [3:0]       sel_q, sel_d;
    logic [3:0]       estatus_q, estatus_d;
    logic [NSRC-1:0]  src_ack_q, src_ack_d;
    logic             bad_eret_q, bad_eret_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [NSRC-1:0]  ready;
    logic [NSRC-1:0]  clr;
    logic [3:0]       pick;
    logic             pick_valid;

    always_comb begin
        ready      = pending_q & mask_q;
        pick       = 4'd0;
        pick_valid = 1'b0;
        // Descending scan so the lowest set index is the one left standing.
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (ready[i]) begin
                pick       = 4'(i);
                pick_valid = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        estatus_d  = estatus_q;
        cnt_d      = cnt_q;
        clr        = '0;
        src_ack_d  = '0;
        bad_eret_d = ERet && (state_q != ST_SERVICE);

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    sel_d     = pick;
                    estatus_d = pick + 4'd1;
                    state_d   = ST_RAISE;
                end
            end
            ST_RAISE: begin
                if (ExcAck) begin
                    clr       = NSRC'(1) << sel_q;
                    src_ack_d = clr;
                    cnt_d     = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                    state_d   = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (ERet) begin
                    estatus_d = 4'd0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A request arriving in the same cycle as the clear keeps the bit set.
        pending_d = (pending_q & ~clr) | src_req;
        mask_d    = cfg_we ? cfg_mask : mask_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            mask_q     <= MASK_RST;
            sel_q      <= 4'd0;
            estatus_q  <= 4'd0;
            src_ack_q  <= '0;
            bad_eret_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            sel_q      <= sel_d;
            estatus_q  <= estatus_d;
            src_ack_q  <= src_ack_d;
            bad_eret_q <= bad_eret_d;
            cnt_q      <= cnt_d;
        end
    end

    assign Exc        = (state_q == ST_RAISE);
    assign in_handler = (state_q == ST_SERVICE);
    assign EStatus    = estatus_q;
    assign src_ack    = src_ack_q;
    assign bad_eret   = bad_eret_q;
    assign exc_count  = cnt_q;

endmodule

// File: tb/tb_exception_arbiter.sv
// tb/tb_exception_arbiter.sv - scoreboard bench for exception_arbiter
// A second instance with a 3-bit counter exercises counter saturation.
module tb_exception_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  src_req = '0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_mask = '0;
    logic        ExcAck = 1'b0;
    logic        ERet = 1'b0;

    logic        exc, exc_s;
    logic [3:0]  est, est_s;
    logic [3:0]  ack, ack_s;
    logic        inh, inh_s;
    logic        bad, bad_s;
    logic [15:0] cnt;
    logic [2:0]  cnt_s;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    exception_arbiter dut (
        .clk(clk), .reset(reset), .src_req(src_req), .cfg_we(cfg_we), .cfg_mask(cfg_mask),
        .ExcAck(ExcAck), .ERet(ERet), .Exc(exc), .EStatus(est), .src_ack(ack),
        .in_handler(inh), .bad_eret(bad), .exc_count(cnt)
    );

    exception_arbiter #(.CNT_W(3)) dut_sat (
        .clk(clk), .reset(reset), .src_req(src_req), .cfg_we(cfg_we), .cfg_mask(cfg_mask),
        .ExcAck(ExcAck), .ERet(ERet), .Exc(exc_s), .EStatus(est_s), .src_ack(ack_s),
        .in_handler(inh_s), .bad_eret(bad_s), .exc_count(cnt_s)
    );

    typedef struct {
        logic       exc;
        logic       inh;
        logic [3:0] est;
        logic [3:0] ack;
        logic       bad;
        int         cnt;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: mode 0 = waiting, 1 = exception offered, 2 = inside handler.
    bit [3:0] m_pend;
    bit [3:0] m_mask;
    int       m_mode;
    int       m_cur;
    int       m_est;
    int       m_cnt;

    task automatic model_step(input logic [3:0] req, input logic we, input logic [3:0] msk,
                              input logic ak, input logic er, input logic rst);
        exp_t e;
        int   taken;
        bit   b;
        taken = -1;
        b     = 1'b0;
        if (rst) begin
            m_pend = '0;
            m_mask = '1;
            m_mode = 0;
            m_cur  = 0;
            m_est  = 0;
            m_cnt  = 0;
        end else begin
            b = er && (m_mode != 2);
            if (m_mode == 0) begin
                for (int i = 0; i < 4; i++) begin
                    if (m_pend[i] && m_mask[i]) begin
                        m_cur  = i;
                        m_est  = i + 1;
                        m_mode = 1;
                        break;
                    end
                end
            end else if (m_mode == 1) begin
                if (ak) begin
                    taken          = m_cur;
                    m_pend[m_cur]  = 1'b0;
                    m_cnt          = m_cnt + 1;
                    m_mode         = 2;
                end
            end else if (er) begin
                m_mode = 0;
                m_est  = 0;
            end
            m_pend = m_pend | req;
            if (we) m_mask = msk;
        end
        e.exc = (m_mode == 1);
        e.inh = (m_mode == 2);
        e.est = 4'(m_est);
        e.ack = (taken >= 0) ? 4'(1 << taken) : 4'd0;
        e.bad = b;
        e.cnt = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [3:0] req, input logic we, input logic [3:0] msk,
                         input logic ak, input logic er, input logic rst);
        @(negedge clk);
        #1;
        src_req  = req;
        cfg_we   = we;
        cfg_mask = msk;
        ExcAck   = ak;
        ERet     = er;
        reset    = rst;
        model_step(req, we, msk, ak, er, rst);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("Exc", int'(exc), int'(e.exc));
                check("in_handler", int'(inh), int'(e.inh));
                check("EStatus", int'(est), int'(e.est));
                check("src_ack", int'(ack), int'(e.ack));
                check("bad_eret", int'(bad), int'(e.bad));
                check("exc_count", int'(cnt), (e.cnt > 65535) ? 65535 : e.cnt);
                check("exc_count_sat", int'(cnt_s), (e.cnt > 7) ? 7 : e.cnt);
                check("sat_inst_exc", int'(exc_s), int'(e.exc));
            end
        end
    end

    initial begin : stimulus
        drive(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
        drive(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
        // single pulse, full handshake
        drive(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        idle(2);
        drive(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
        idle(1);
        drive(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
        idle(2);
        // two sources at once, priority order
        drive(4'b1010, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        idle(2);
        drive(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
        idle(1);
        drive(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
        idle(2);
        drive(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
        drive(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
        idle(1);
        // masked source held pending until unmasked
        drive(4'b0000, 1'b1, 4'b1110, 1'b0, 1'b0, 1'b0);
        drive(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        idle(3);
        drive(4'b0000, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
        idle(2);
        drive(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
        drive(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
        idle(1);
        // request arriving in the handler waits for ERet
        drive(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        idle(2);
        drive(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
        drive(4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        idle(2);
        drive(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
        idle(2);
        drive(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
        drive(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
        // stray ERet / ExcAck while idle
        drive(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
        drive(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
        idle(1);
        // ExcAck together with ERet while raised; re-set of the bit being cleared
        drive(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        idle(2);
        drive(4'b0001, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);
        idle(1);
        drive(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
        idle(2);
        drive(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
        drive(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
        // reset while raised, then while in the handler
        drive(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        idle(2);
        drive(4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
        idle(3);
        drive(4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        idle(2);
        drive(4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
        drive(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
        idle(3);
        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            logic [3:0] r;
            r = 4'($urandom) & 4'($urandom) & 4'($urandom);
            drive(r, ($urandom % 16) == 0, 4'($urandom), ($urandom % 3) == 0,
                  ($urandom % 4) == 0, ($urandom % 300) == 0);
        end
        idle(1);
        @(negedge clk);
        @(negedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
